// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared types and constants for the multiplier-sharing arbiter
// Contents:
//   state_t   : arbiter FSM states (IDLE, EXEC, RESP)
//   OPERAND_W : operand width of the shared multiplier
//   PRODUCT_W : full product width of the shared multiplier
//   idx_w()   : width of a requester index for a given requester count
package mul_share_pkg;

   localparam int OPERAND_W = 16;
   localparam int PRODUCT_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // At least one bit, so a two-requester build still has a usable index.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/accelerator_core.sv
// rtl/accelerator_core.sv - registered 16x16 unsigned multiplier with overflow flag
// Ports:
//   clk, wb_rst_i  : clock, asynchronous active-high reset
//   en             : capture strobe; outputs update on the edge ending an en cycle
//   a, b           : unsigned operands
//   result         : low half of the product (registered)
//   overflow       : product exceeded the operand width (registered)
module accelerator_core
   import mul_share_pkg::*;
(
   input  logic                 clk,
   input  logic                 wb_rst_i,
   input  logic                 en,
   input  logic [OPERAND_W-1:0] a,
   input  logic [OPERAND_W-1:0] b,
   output logic [OPERAND_W-1:0] result,
   output logic                 overflow
);

   logic [PRODUCT_W-1:0] product;

   assign product = PRODUCT_W'(a) * PRODUCT_W'(b);

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         result   <= '0;
         overflow <= 1'b0;
      end else if (en) begin
         result   <= product[OPERAND_W-1:0];
         overflow <= |product[PRODUCT_W-1:OPERAND_W];
      end
   end

endmodule

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// rtl/mul_share_arbiter_rr_arbiter.sv - pointer-based round-robin one-hot grant
// Ports:
//   clk, wb_rst_i : clock, asynchronous active-high reset
//   req           : per-requester request vector
//   advance       : move the pointer to one past last_idx
//   last_idx      : index of the requester just served
//   grant         : one-hot (or zero) grant, first request at or above the pointer
//   grant_idx     : binary index of the granted requester
module rr_arbiter
   import mul_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_w(NUM_REQ)
)(
   input  logic               clk,
   input  logic               wb_rst_i,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   input  logic [IDX_W-1:0]   last_idx,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;
   logic             found;

   // Scan NUM_REQ candidates starting at the pointer; the extra sum bit
   // lets the wrap use a plain subtract for non-power-of-two counts.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         sum = {1'b0, ptr_q} + (IDX_W+1)'(off);
         if (sum >= (IDX_W+1)'(NUM_REQ))
            sum = sum - (IDX_W+1)'(NUM_REQ);
         cand = sum[IDX_W-1:0];
         if (!found && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            found       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i)
         ptr_q <= '0;
      else if (advance)
         ptr_q <= (last_idx == IDX_W'(NUM_REQ-1)) ? '0 : last_idx + IDX_W'(1);
   end

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one multiplier among NUM_REQ requesters
// Ports:
//   clk, wb_rst_i          : clock, asynchronous active-high reset
//   req_valid/req_ready    : per-requester request handshake (ready one-hot or zero)
//   req_a, req_b           : packed 16-bit operands, slice i for requester i
//   rsp_valid/rsp_ready    : per-requester response handshake (valid one-hot or zero)
//   rsp_result             : low 16 bits of the product, shared bus
//   rsp_overflow           : product did not fit in 16 bits, shared bus
//   busy                   : FSM not in IDLE
//   stat_clr               : synchronous clear of both statistics counters
//   stat_ops, stat_ovf     : saturating counts of completed / overflowing operations
module mul_share_arbiter
   import mul_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
)(
   input  logic                           clk,
   input  logic                           wb_rst_i,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*OPERAND_W-1:0]   req_a,
   input  logic [NUM_REQ*OPERAND_W-1:0]   req_b,
   output logic [NUM_REQ-1:0]             rsp_valid,
   input  logic [NUM_REQ-1:0]             rsp_ready,
   output logic [OPERAND_W-1:0]           rsp_result,
   output logic                           rsp_overflow,
   output logic                           busy,
   input  logic                           stat_clr,
   output logic [CNT_W-1:0]               stat_ops,
   output logic [CNT_W-1:0]               stat_ovf
);

   localparam int IDX_W = idx_w(NUM_REQ);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     winner_q;
   logic [IDX_W-1:0]     grant_idx;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   arb_req;
   logic [OPERAND_W-1:0] op_a_q, op_b_q;
   logic [OPERAND_W-1:0] sel_a, sel_b;
   logic                 accept;
   logic                 rsp_hs;

   // Requests are only visible to the arbiter in IDLE, so req_ready is
   // zero in EXEC and RESP without any extra gating.
   assign arb_req = (state_q == IDLE) ? req_valid : '0;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .clk       (clk),
      .wb_rst_i  (wb_rst_i),
      .req       (arb_req),
      .advance   (rsp_hs),
      .last_idx  (winner_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;
   assign accept    = |grant;
   assign rsp_hs    = (state_q == RESP) && rsp_ready[winner_q];
   assign busy      = (state_q != IDLE);

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_a = req_a[i*OPERAND_W +: OPERAND_W];
            sel_b = req_b[i*OPERAND_W +: OPERAND_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         op_a_q   <= '0;
         op_b_q   <= '0;
         winner_q <= '0;
      end else if (state_q == IDLE && accept) begin
         op_a_q   <= sel_a;
         op_b_q   <= sel_b;
         winner_q <= grant_idx;
      end
   end

   // The operand registers stay put until the next accept, and the core
   // only captures in EXEC, so the response bus is stable through RESP.
   accelerator_core u_accelerator_core (
      .clk      (clk),
      .wb_rst_i (wb_rst_i),
      .en       (state_q == EXEC),
      .a        (op_a_q),
      .b        (op_b_q),
      .result   (rsp_result),
      .overflow (rsp_overflow)
   );

   always_comb begin
      rsp_valid = '0;
      if (state_q == RESP)
         rsp_valid[winner_q] = 1'b1;
   end

   // Clear wins over a coincident increment; both counters stick at all-ones.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         stat_ops <= '0;
         stat_ovf <= '0;
      end else if (stat_clr) begin
         stat_ops <= '0;
         stat_ovf <= '0;
      end else if (rsp_hs) begin
         if (!(&stat_ops))
            stat_ops <= stat_ops + CNT_W'(1);
         if (rsp_overflow && !(&stat_ovf))
            stat_ovf <= stat_ovf + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard bench for mul_share_arbiter
module tb_mul_share_arbiter;

   localparam int N      = 4;
   localparam int CW     = 4;
   localparam int CMAX   = (1 << CW) - 1;
   localparam int BUDGET = 300;

   logic            clk = 1'b0;
   logic            wb_rst_i;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*16-1:0] req_a;
   logic [N*16-1:0] req_b;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [15:0]     rsp_result;
   logic            rsp_overflow;
   logic            busy;
   logic            stat_clr;
   logic [CW-1:0]   stat_ops;
   logic [CW-1:0]   stat_ovf;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [16:0] exp_q [N][$];
   int          grant_log[$];

   mul_share_arbiter #(
      .NUM_REQ (N),
      .CNT_W   (CW)
   ) dut (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_overflow (rsp_overflow),
      .busy         (busy),
      .stat_clr     (stat_clr),
      .stat_ops     (stat_ops),
      .stat_ovf     (stat_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: unsigned product, low half plus "did not fit" flag.
   function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
      longint unsigned p;
      p = longint'(a) * longint'(b);
      return {(p > 64'd65535), 16'(p % 64'd65536)};
   endfunction

   task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[i*16 +: 16] = a;
      req_b[i*16 +: 16] = b;
      req_valid[i]      = 1'b1;
      exp_q[i].push_back(model(a, b));
   endtask

   // One clock: note accepts before the edge, drop those valids after it.
   task automatic step();
      logic [N-1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
      stat_clr  = 1'b0;
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < N; i++)
         if (exp_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input string name);
      int n;
      n = 0;
      rsp_ready = '1;
      while ((req_valid != 0 || !all_empty()) && n < BUDGET) begin
         step();
         n++;
      end
      if (n >= BUDGET) chk(1'b0, name, n, BUDGET);
   endtask

   function automatic logic [15:0] rand_op();
      case ($urandom_range(0, 3))
         0:       return 16'($urandom);
         1:       return 16'($urandom_range(0, 255));
         2:       return 16'hFFFF;
         default: return 16'(1 << $urandom_range(0, 15));
      endcase
   endfunction

   // Monitor: an independent picture of the arbiter (pointer, current
   // winner, counters) driven purely by the handshakes it observes.
   initial begin
      int          m_ptr, m_win, m_acc, m_ops, m_ovf, c, w;
      int          wait_ops[N];
      logic [N-1:0] exp_rdy;
      logic [16:0] e;
      m_ptr = 0; m_win = -1; m_acc = 0; m_ops = 0; m_ovf = 0;
      for (int i = 0; i < N; i++) wait_ops[i] = 0;
      forever begin
         @(negedge clk);
         if (wb_rst_i) begin
            m_ptr = 0; m_win = -1; m_ops = 0; m_ovf = 0;
            for (int i = 0; i < N; i++) begin
               exp_q[i].delete();
               wait_ops[i] = 0;
            end
         end else begin
            chk(stat_ops == CW'(m_ops), "stat_ops", stat_ops, m_ops);
            chk(stat_ovf == CW'(m_ovf), "stat_ovf", stat_ovf, m_ovf);
            chk($onehot0(rsp_valid), "rsp_valid_onehot0", rsp_valid, 0);
            if (m_win < 0) begin
               exp_rdy = '0;
               w = -1;
               for (int k = 0; k < N; k++) begin
                  c = (m_ptr + k) % N;
                  if (req_valid[c] && w < 0) begin
                     exp_rdy[c] = 1'b1;
                     w = c;
                  end
               end
               chk(req_ready == exp_rdy, "grant", req_ready, exp_rdy);
               chk(busy == 1'b0, "busy_idle", busy, 0);
               chk(rsp_valid == '0, "rsp_valid_idle", rsp_valid, 0);
               if (w >= 0) begin
                  grant_log.push_back(w);
                  chk(wait_ops[w] < N, "fairness", wait_ops[w], N - 1);
                  for (int j = 0; j < N; j++) begin
                     if (j == w || !req_valid[j]) wait_ops[j] = 0;
                     else wait_ops[j]++;
                  end
                  m_win = w;
                  m_acc = cyc;
               end
            end else begin
               chk(req_ready == '0, "req_ready_busy", req_ready, 0);
               chk(busy == 1'b1, "busy_active", busy, 1);
               if (cyc - m_acc == 1) begin
                  chk(rsp_valid == '0, "rsp_valid_exec", rsp_valid, 0);
               end else begin
                  chk(rsp_valid == (N'(1) << m_win), "rsp_valid_winner", rsp_valid, N'(1) << m_win);
                  if (exp_q[m_win].size() == 0) begin
                     chk(1'b0, "rsp_without_request", m_win, 0);
                  end else begin
                     e = exp_q[m_win][0];
                     chk(rsp_result == e[15:0], "rsp_result", rsp_result, e[15:0]);
                     chk(rsp_overflow == e[16], "rsp_overflow", rsp_overflow, e[16]);
                     if (rsp_ready[m_win]) begin
                        void'(exp_q[m_win].pop_front());
                        if (m_ops < CMAX) m_ops++;
                        if (e[16] && m_ovf < CMAX) m_ovf++;
                        m_ptr = (m_win + 1) % N;
                        m_win = -1;
                     end
                  end
               end
            end
            if (stat_clr) begin
               m_ops = 0;
               m_ovf = 0;
            end
         end
      end
   end

   initial begin
      int n;
      int exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};
      wb_rst_i  = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      stat_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk(req_ready == '0,     "rst_req_ready", req_ready, 0);
      chk(rsp_valid == '0,     "rst_rsp_valid", rsp_valid, 0);
      chk(rsp_result == '0,    "rst_rsp_result", rsp_result, 0);
      chk(rsp_overflow == 1'b0, "rst_rsp_overflow", rsp_overflow, 0);
      chk(busy == 1'b0,        "rst_busy", busy, 0);
      chk(stat_ops == '0,      "rst_stat_ops", stat_ops, 0);
      chk(stat_ovf == '0,      "rst_stat_ovf", stat_ovf, 0);
      wb_rst_i = 1'b0;

      // Reset while requester 2 is in EXEC: drop the operation entirely.
      issue(2, 16'd3, 16'd5);
      step();
      #1;
      wb_rst_i = 1'b1;
      #1;
      chk(rsp_valid == '0,  "midrst_rsp_valid", rsp_valid, 0);
      chk(busy == 1'b0,     "midrst_busy", busy, 0);
      chk(rsp_result == '0, "midrst_rsp_result", rsp_result, 0);
      chk(stat_ops == '0,   "midrst_stat_ops", stat_ops, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      wb_rst_i  = 1'b0;
      rsp_ready = '1;
      repeat (4) step();
      grant_log.delete();
      issue(0, 16'd7, 16'd9);
      issue(2, 16'd11, 16'd13);
      drain("drain_after_reset");
      chk(grant_log.size() == 2 && grant_log[0] == 0, "ptr_zero_after_reset", grant_log.size(), 2);

      // Single requester and overflow patterns.
      issue(0, 16'h0012, 16'h0034);
      drain("drain_single");
      issue(3, 16'h0100, 16'h0100);
      drain("drain_ovf");
      issue(3, 16'hFFFF, 16'h0001);
      drain("drain_ffff");

      // All requesters continuously valid.
      grant_log.delete();
      for (int i = 0; i < N; i++) issue(i, rand_op(), rand_op());
      n = 0;
      while (grant_log.size() < 5 && n < BUDGET) begin
         step();
         for (int i = 0; i < N; i++)
            if (!req_valid[i]) issue(i, rand_op(), rand_op());
         n++;
      end
      drain("drain_all_valid");
      if (grant_log.size() < 5) chk(1'b0, "grant_order_timeout", grant_log.size(), 5);
      else for (int k = 0; k < 5; k++)
         chk(grant_log[k] == exp_order[k], "grant_order", grant_log[k], exp_order[k]);

      // Response backpressure with another requester waiting.
      rsp_ready = '0;
      issue(1, 16'h1234, 16'h0003);
      issue(2, 16'h0002, 16'h0002);
      repeat (8) step();
      drain("drain_backpressure");

      // Randomized traffic.
      for (int r = 0; r < 400; r++) begin
         step();
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0) issue(i, rand_op(), rand_op());
         rsp_ready = N'($urandom);
         if ($urandom_range(0, 49) == 0) stat_clr = 1'b1;
      end
      drain("drain_random");

      // Saturation: 18 overflowing operations after a clear.
      stat_clr = 1'b1;
      step();
      for (int k = 0; k < 18; k++) begin
         issue(k % N, 16'hFFFF, 16'hFFFF);
         drain("drain_sat");
      end
      chk(stat_ops == CW'(CMAX), "sat_stat_ops", stat_ops, CMAX);
      chk(stat_ovf == CW'(CMAX), "sat_stat_ovf", stat_ovf, CMAX);

      // Clear coinciding with a response handshake.
      rsp_ready = '0;
      issue(0, 16'd2, 16'd3);
      n = 0;
      while (rsp_valid[0] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) chk(1'b0, "clr_hs_timeout", n, 20);
      stat_clr  = 1'b1;
      rsp_ready = '1;
      step();
      #1;
      chk(stat_ops == '0, "clr_hs_stat_ops", stat_ops, 0);
      chk(stat_ovf == '0, "clr_hs_stat_ovf", stat_ovf, 0);
      drain("drain_final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one 16x16 multiplier datapath (the existing `accelerator_core` instance) between NUM_REQ independent requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake for the request and for the response.
- Operands are latched, the multiplier is sequenced through its one-cycle registered latency, and result and overflow are routed back only to the granted requester.
- The block also keeps operation and overflow statistics counters for software visibility.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept; one-hot or zero.
- req_a  in  NUM_REQ*16  packed operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*16  packed operand B; slice i belongs to requester i.
- rsp_valid  out  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_result  out  16  low 16 bits of the product; shared bus, qualified by rsp_valid.
- rsp_overflow  out  1  product did not fit in 16 bits; shared bus.
- busy  out  1  high in any state other than IDLE.
- stat_clr  in  1  synchronous clear of both statistics counters.
- stat_ops  out  CNT_W  count of completed operations, saturating.
- stat_ovf  out  CNT_W  count of completed operations with overflow, saturating.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_overflow=0, busy=0, stat_ops=0, stat_ovf=0. Round-robin pointer=0, state=IDLE, operand registers=0.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - req_ready is combinational. It is one-hot on the first requester i with req_valid[i]=1, searching from the pointer upward with wrap-around.
  - On a cycle where req_valid[i] & req_ready[i], req_a[i] and req_b[i] are latched into the operand registers, the winner index is stored, and the state goes to EXEC.
  - With no request, the block stays in IDLE and req_ready=0.
- EXEC: lasts exactly one cycle. The operand registers drive the multiplier inputs, which capture at the end of this cycle. The state then goes to RESP.
- RESP:
  - rsp_valid[winner]=1; all other rsp_valid bits are 0.
  - rsp_result and rsp_overflow come from the multiplier outputs and are held stable.
  - The block stays in RESP until rsp_ready[winner]=1. On that cycle the state goes to IDLE, the pointer becomes (winner+1) mod NUM_REQ, and the counters update.
  - rsp_ready on non-winners is ignored.
- Latency: request accept edge to rsp_valid is 2 cycles. Best-case throughput is one operation per 3 cycles.
- req_ready is 0 in EXEC and RESP. A request that arrives while busy waits; requesters must hold req_valid and operands stable until accepted.
- Arithmetic:
  - Operands are unsigned 16-bit.
  - rsp_result = product[15:0].
  - rsp_overflow = 1 iff product > 0xFFFF (any of bits [31:16] nonzero).
- Fairness: a requester holding req_valid is granted within NUM_REQ operations.
- Counters:
  - stat_ops increments by 1 on each response handshake.
  - stat_ovf increments by 1 on each response handshake where rsp_overflow=1.
  - Both saturate at all-ones and do not wrap.
  - stat_clr has priority over a simultaneous increment; the counter reads 0 the next cycle.
- Reset mid-operation (EXEC or RESP): everything returns to reset values immediately. The in-flight operation is dropped with no response and is not counted.
- Out-of-range pointer or winner values cannot occur. The pointer wrap uses an explicit compare with NUM_REQ-1, not a power-of-two mask.

Decomposition:
- Shared package mul_share_pkg holds:
  - state enum typedef (IDLE, EXEC, RESP);
  - OPERAND_W=16 and PRODUCT_W=32 constants;
  - the NUM_REQ-dependent index width helper function.
- One natural sub-module, rr_arbiter: pointer-based combinational one-hot grant plus pointer update on an advance strobe, parameterised by NUM_REQ.
- The multiplier itself is instantiated unchanged inside mul_share_arbiter.

Test Plan:
- Single requester 0: a=0x0012, b=0x0034 -> req_ready[0] on the same cycle; rsp_valid[0] 2 cycles later with result=0x03A8, overflow=0; stat_ops=1.
- Overflow: a=0x0100, b=0x0100 -> result=0x0000, overflow=1; stat_ovf=1. Then a=0xFFFF, b=0x0001 -> result=0xFFFF, overflow=0.
- All four requesters valid continuously -> grant order 0,1,2,3,0. No requester is granted twice before the others; rsp_valid is always one-hot.
- Response backpressure: rsp_ready held low 5 cycles -> rsp_valid and result held stable; req_ready=0 on all requesters throughout; next grant only after the handshake.
- Reset asserted in EXEC with requester 2 granted -> all outputs 0 asynchronously; no response after release; pointer=0; stat_ops unchanged at 0.
- Counter saturation and clear: preload via 0xFFFF ops (or force CNT_W=4 and run 16 ops) -> counter stays at 0xF; stat_clr asserted together with a handshake -> counter reads 0.
